// File: rtl/parking_fee_calc.sv
// Parking fee calculator: per-slot entry time table, fee on exit.
// Ports: clk/reset, day/hour/minute, entry/exit req+slot; busy, fee_valid, fee, duration, err, occupied, free_count. Option: FEE_CAP_EN.
module parking_fee_calc #(
  parameter int N_SLOTS   = 16,
  parameter int SLOT_W    = 4,
  parameter int FREE_MIN  = 15,
  parameter int RATE_HOUR = 5,
  parameter int FEE_W     = 16,
  parameter int FEE_CAP   = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          day,
  input  logic [4:0]          hour,
  input  logic [6:0]          minute,
  input  logic                entry_req,
  input  logic [SLOT_W-1:0]   entry_slot,
  input  logic                exit_req,
  input  logic [SLOT_W-1:0]   exit_slot,
  output logic                busy,
  output logic                fee_valid,
  output logic [FEE_W-1:0]    fee,
  output logic [17:0]         duration,
  output logic                err,
  output logic [N_SLOTS-1:0]  occupied,
  output logic [SLOT_W:0]     free_count
);

  localparam logic [18:0] WRAP = 19'd184320;
  localparam logic [31:0] FMAX = 32'((64'd1 << FEE_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DIV,
    S_FEE
  } state_t;

  state_t r_state, w_next;

  logic [17:0]        r_tbl [N_SLOTS];
  logic [N_SLOTS-1:0] r_occ;
  logic [SLOT_W:0]    r_free;
  logic               r_err, r_fee_valid;
  logic [FEE_W-1:0]   r_fee;
  logic [17:0]        r_duration;
  logic [17:0]        r_exit_abs, r_entry_abs, r_dur;
  logic [17:0]        r_quo;
  logic [5:0]         r_rem;
  logic [4:0]         r_cnt;

  logic        w_busy;
  logic [17:0] w_abs;
  logic        w_ent_rng, w_ext_rng;
  logic        w_exit_ok, w_exit_bad;
  logic        w_entry_ok, w_entry_bad;
  logic [18:0] w_diff;
  logic [17:0] w_dur, w_div_in;
  logic [6:0]  w_trial;
  logic [31:0] w_prod, w_fee;

  // fee_valid cycle still counts as busy
  assign w_busy = (r_state != S_IDLE) | r_fee_valid;

  assign w_abs = 18'(day) * 18'd1440
               + 18'(hour) * 18'd60
               + 18'(minute);

  assign w_ent_rng = ({1'b0, entry_slot} < (SLOT_W+1)'(N_SLOTS));
  assign w_ext_rng = ({1'b0, exit_slot} < (SLOT_W+1)'(N_SLOTS));

  // exit wins over a simultaneous entry
  assign w_exit_ok   = exit_req & ~w_busy
                     & w_ext_rng & r_occ[exit_slot];
  assign w_exit_bad  = exit_req & ~w_busy & ~w_exit_ok;
  assign w_entry_ok  = entry_req & ~exit_req & ~w_busy
                     & w_ent_rng & ~r_occ[entry_slot];
  assign w_entry_bad = entry_req & ~exit_req & ~w_busy
                     & ~w_entry_ok;

  always_comb begin
    w_diff = {1'b0, r_exit_abs} - {1'b0, r_entry_abs};
    if (r_exit_abs < r_entry_abs)
      w_diff = w_diff + WRAP;
    w_dur = w_diff[17:0];
    if (w_dur > 18'(FREE_MIN))
      w_div_in = w_dur - 18'(FREE_MIN) + 18'd59;
    else
      w_div_in = 18'd59;
  end

  assign w_trial = {r_rem, r_quo[17]};

  always_comb begin
    w_prod = 32'(r_quo) * 32'(RATE_HOUR);
    w_fee  = (w_prod > FMAX) ? FMAX : w_prod;
`ifdef FEE_CAP_EN
    if (w_fee > 32'(FEE_CAP))
      w_fee = 32'(FEE_CAP);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_exit_ok) w_next = S_CALC;
      S_CALC: w_next = S_DIV;
      S_DIV:  if (r_cnt == 5'd17) w_next = S_FEE;
      S_FEE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_entry_ok)
      r_tbl[entry_slot] <= w_abs;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ       <= '0;
      r_free      <= (SLOT_W+1)'(N_SLOTS);
      r_err       <= 1'b0;
      r_fee_valid <= 1'b0;
      r_fee       <= '0;
      r_duration  <= '0;
      r_exit_abs  <= '0;
      r_entry_abs <= '0;
      r_dur       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
    end else begin
      r_err       <= w_exit_bad | w_entry_bad;
      r_fee_valid <= 1'b0;
      if (w_exit_ok) begin
        r_occ[exit_slot] <= 1'b0;
        r_free      <= r_free + 1'b1;
        r_exit_abs  <= w_abs;
        r_entry_abs <= r_tbl[exit_slot];
      end else if (w_entry_ok) begin
        r_occ[entry_slot] <= 1'b1;
        r_free <= r_free - 1'b1;
      end
      unique case (r_state)
        S_CALC: begin
          r_dur <= w_dur;
          r_quo <= w_div_in;
          r_rem <= '0;
          r_cnt <= '0;
        end
        S_DIV: begin
          // restoring step: quotient bits shift in from the right
          if (w_trial >= 7'd60) begin
            r_rem <= 6'(w_trial - 7'd60);
            r_quo <= {r_quo[16:0], 1'b1};
          end else begin
            r_rem <= w_trial[5:0];
            r_quo <= {r_quo[16:0], 1'b0};
          end
          r_cnt <= r_cnt + 5'd1;
        end
        S_FEE: begin
          r_fee       <= w_fee[FEE_W-1:0];
          r_duration  <= r_dur;
          r_fee_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = w_busy;
  assign fee_valid  = r_fee_valid;
  assign fee        = r_fee;
  assign duration   = r_duration;
  assign err        = r_err;
  assign occupied   = r_occ;
  assign free_count = r_free;

endmodule

// File: tb/tb_parking_fee_calc.sv
// Directed bench for parking_fee_calc.
// Hand-computed fees, latency, errors, priority, wrap, cap, abort.
module tb_parking_fee_calc;

  logic        clk, reset;
  logic [6:0]  day;
  logic [4:0]  hour;
  logic [6:0]  minute;
  logic        entry_req, exit_req;
  logic [3:0]  entry_slot, exit_slot;
  logic        busy, fee_valid, err;
  logic [15:0] fee;
  logic [17:0] duration;
  logic [15:0] occupied;
  logic [4:0]  free_count;

  int total = 0;
  int bad   = 0;

  parking_fee_calc dut (
    .clk(clk), .reset(reset),
    .day(day), .hour(hour), .minute(minute),
    .entry_req(entry_req), .entry_slot(entry_slot),
    .exit_req(exit_req), .exit_slot(exit_slot),
    .busy(busy), .fee_valid(fee_valid), .fee(fee),
    .duration(duration), .err(err),
    .occupied(occupied), .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_t(input int d, input int h, input int m);
    day    = 7'(d);
    hour   = 5'(h);
    minute = 7'(m);
  endtask

  task automatic do_entry(input int s, input int d,
                          input int h, input int m);
    @(negedge clk);
    set_t(d, h, m);
    entry_req  = 1'b1;
    entry_slot = 4'(s);
    @(posedge clk); #1;
    entry_req = 1'b0;
    check("entry_err", err, 0);
  endtask

  task automatic do_exit(input string tag, input int s,
                         input int d, input int h, input int m,
                         input int edur, input int efee,
                         input bit noise);
    int lat, nb;
    @(negedge clk);
    set_t(d, h, m);
    exit_req  = 1'b1;
    exit_slot = 4'(s);
    if (noise) begin
      entry_req  = 1'b1;
      entry_slot = 4'd0;
    end
    @(posedge clk); #1;
    exit_req  = 1'b0;
    entry_req = 1'b0;
    set_t(0, 0, 0);
    check({tag, "_busy0"}, busy, 1);
    if (noise) check({tag, "_slot0"}, occupied[0], 0);
    lat = -1;
    nb  = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) nb++;
      if (fee_valid && lat < 0) begin
        lat = k;
        check({tag, "_fee"}, fee, efee);
        check({tag, "_dur"}, duration, edur);
      end
      if (noise) begin
        check({tag, "_noerr"}, err, 0);
        if (k >= 1 && k <= 3) begin
          entry_req  = 1'b1;
          entry_slot = 4'd10;
          exit_req   = 1'b1;
          exit_slot  = 4'd3;
        end else begin
          entry_req = 1'b0;
          exit_req  = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    check({tag, "_lat"}, lat, 20);
    check({tag, "_busycyc"}, nb, 21);
    check({tag, "_hold"}, fee, efee);
  endtask

  initial begin
    int seen;
    reset = 1'b0;
    entry_req = 0; exit_req = 0;
    entry_slot = 0; exit_slot = 0;
    set_t(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      entry_req  = 1'($urandom);
      exit_req   = 1'($urandom);
      entry_slot = 4'($urandom);
      exit_slot  = 4'($urandom);
      set_t($urandom_range(127), $urandom_range(23),
            $urandom_range(59));
      @(posedge clk); #1;
      check("rst_occ", occupied, 0);
      check("rst_free", free_count, 16);
      check("rst_busy", busy, 0);
      check("rst_fv", fee_valid, 0);
      check("rst_err", err, 0);
      check("rst_fee", fee, 0);
      check("rst_dur", duration, 0);
    end
    @(negedge clk);
    entry_req = 0; exit_req = 0;
    reset = 1'b1;

    do_entry(3, 0, 0, 0);
    check("e3_occ", occupied, 16'h0008);
    check("e3_free", free_count, 15);

    do_entry(2, 0, 8, 0);
    check("e2_occ", occupied, 16'h000C);
    do_exit("norm", 2, 0, 10, 30, 150, 15, 0);
    check("norm_occ", occupied, 16'h0008);
    check("norm_free", free_count, 15);

    do_entry(4, 5, 12, 0);
    do_exit("grace", 4, 5, 12, 10, 10, 0, 0);
    do_entry(5, 0, 23, 50);
    do_exit("dayb", 5, 1, 0, 20, 30, 5, 0);
    do_entry(6, 127, 23, 0);
    do_exit("wrap", 6, 0, 1, 0, 120, 10, 0);
    do_entry(7, 9, 9, 9);
    do_exit("equal", 7, 9, 9, 9, 0, 0, 0);
`ifdef FEE_CAP_EN
    do_entry(8, 0, 0, 0);
    do_exit("cap", 8, 2, 0, 0, 2880, 200, 0);
`else
    do_entry(8, 0, 0, 0);
    do_exit("cap", 8, 2, 0, 0, 2880, 240, 0);
`endif

    @(negedge clk);
    entry_req  = 1'b1;
    entry_slot = 4'd3;
    @(posedge clk); #1;
    entry_req = 1'b0;
    check("occ_err", err, 1);
    check("occ_map", occupied, 16'h0008);
    @(posedge clk); #1;
    check("occ_err1", err, 0);

    @(negedge clk);
    exit_req  = 1'b1;
    exit_slot = 4'd9;
    @(posedge clk); #1;
    exit_req = 1'b0;
    check("empty_err", err, 1);
    check("empty_busy", busy, 0);
    @(posedge clk); #1;
    check("empty_busy1", busy, 0);
    check("empty_err1", err, 0);

    do_entry(2, 3, 0, 0);
    do_exit("prio", 2, 3, 1, 0, 60, 5, 1);
    check("prio_occ", occupied, 16'h0008);
    check("prio_free", free_count, 15);

    do_entry(1, 0, 0, 0);
    @(negedge clk);
    set_t(0, 5, 0);
    exit_req  = 1'b1;
    exit_slot = 4'd1;
    @(posedge clk); #1;
    exit_req = 1'b0;
    repeat (8) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_occ", occupied, 0);
    check("abort_free", free_count, 16);
    check("abort_fee", fee, 0);
    check("abort_dur", duration, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (fee_valid || busy) seen++;
    end
    check("abort_nofv", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_fee_calc.md
Name: parking_fee_calc

Overview:
- Consumes the day/hour/minute time stamp from clock_counter; tracks per-slot entry times and computes the parking fee when a car leaves.
- Entry request latches the current time for a slot. Exit request computes elapsed minutes, subtracts a free grace period, rounds up to whole hours and multiplies by an hourly rate.
- Result is presented with a one-cycle valid strobe to the downstream billing/display logic.

Parameters:
- N_SLOTS, 16, number of parking slots tracked
- SLOT_W, 4, slot index width; N_SLOTS <= 2**SLOT_W
- FREE_MIN, 15, free minutes before billing starts
- RATE_HOUR, 5, fee units per started billable hour
- FEE_W, 16, fee output width; fee saturates at 2**FEE_W-1
- FEE_CAP, 200, maximum fee per stay; used only when FEE_CAP_EN is defined

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- day  in  7  current day from clock_counter, 0..127
- hour  in  5  current hour, 0..23
- minute  in  7  current minute, 0..59
- entry_req  in  1  car entering; sampled when busy=0
- entry_slot  in  SLOT_W  slot for entry
- exit_req  in  1  car leaving; sampled when busy=0
- exit_slot  in  SLOT_W  slot for exit
- busy  out  1  fee computation in progress
- fee_valid  out  1  one-cycle strobe; fee and duration are valid
- fee  out  FEE_W  computed fee, held until the next fee_valid
- duration  out  18  elapsed minutes of the last completed exit
- err  out  1  one-cycle strobe for a rejected request
- occupied  out  N_SLOTS  per-slot occupancy bitmap
- free_count  out  SLOT_W+1  number of unoccupied slots

Behaviour:
- Reset (reset=0, async): busy=0, fee_valid=0, err=0, fee=0, duration=0, occupied=0, free_count=N_SLOTS, FSM=IDLE. Entry-time table is don't-care.
- Absolute time: abs = day*1440 + hour*60 + minute, 18 bits, range 0..184319.
- FSM states and transitions:
  - IDLE: accepts requests.
  - CALC: dur = (exit_abs - entry_abs) mod 184320. bill = dur > FREE_MIN ? dur-FREE_MIN : 0. Dividend = bill+59.
  - DIV: 18-cycle restoring division by 60, giving hours = ceil(bill/60).
  - FEE: fee = hours*RATE_HOUR, saturated to FEE_W bits; duration=dur; fee_valid=1 for one cycle; return to IDLE.
- Latency: if the accepting edge is E0, then CALC runs at E1, DIV at E2..E19, and fee/fee_valid register at E20. fee_valid is high for the single cycle after E20.
- busy is high from the cycle after E0 through the fee_valid cycle inclusive. Requests are ignored (no err) while busy=1.
- Entry in IDLE:
  - If slot < N_SLOTS and the slot is free: store abs for the slot, set its occupied bit, decrement free_count.
  - Otherwise: err for one cycle, no state change.
- Exit in IDLE:
  - If the slot is occupied: clear its occupied bit and increment free_count at E0, then start computation.
  - If the slot is empty or the index is out of range: err for one cycle, no computation, busy stays 0.
- Simultaneous entry_req and exit_req in IDLE: exit has priority; entry is dropped silently and the caller retries.
- Wrap-around: exit time earlier than entry time is treated as a day-counter wrap (mod 184320). Equal times give dur=0 and fee=0.
- Inputs day/hour/minute are sampled at the accepting edge only.
- Reset mid-computation aborts immediately: no fee_valid, all outputs return to their reset values.

Optional Feature:
- Macro FEE_CAP_EN.
  - Defined: fee = min(computed fee, FEE_CAP), applied in the FEE state with no latency change.
  - Undefined: no cap beyond FEE_W saturation; FEE_CAP is unused.

Test Plan:
- Reset: hold reset=0 with random inputs -> occupied=0, free_count=16, busy=0, fee=0, no fee_valid/err strobes; release, then entry slot 3 -> occupied=0x0008, free_count=15.
- Normal stay: entry slot 2 at d0 08:00, exit at d0 10:30 -> duration=150, fee=15 (3 h), fee_valid exactly 20 edges after exit accept, busy high for 21 cycles.
- Grace period and day boundary: stay d5 12:00 to d5 12:10 -> fee=0, duration=10. Stay d0 23:50 to d1 00:20 -> duration=30, fee=5.
- Counter wrap: entry d127 23:00, exit d0 01:00 -> duration=120, fee=10.
- Errors and priority:
  - Entry on an occupied slot -> err one cycle, occupancy unchanged.
  - Exit on an empty slot -> err, busy stays 0.
  - entry_slot=0 and exit_slot=2 (occupied) asserted together -> exit runs and slot 0 stays free.
  - Requests during busy -> ignored.
- Cap and reset abort: stay d0 00:00 to d2 00:00 -> duration=2880, fee=200 with FEE_CAP_EN, 240 without. Separately, reset pulsed during DIV -> no fee_valid, busy=0, occupied=0.
